// File: rtl/axi_i2c_pkg.sv
// Shared types and constants for the AXI4-Lite to I2C command bridge.
package axi_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    ISSUE,
    WAIT_DONE,
    WR_RESP,
    RD_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Address field map: [14:8] I2C slave address, [7:0] register address.
  localparam int SLV_LSB = 8;
  localparam int SLV_MSB = 14;
  localparam int REG_MSB = 7;

endpackage

// File: rtl/i2c_cmd_timeout.sv
// Loadable down-counter guarding the wait for the I2C master's done pulse.
// start loads TIMEOUT_CYC-1; expired is high once the count has run down to
// zero, i.e. on the TIMEOUT_CYC-th cycle after start.
module i2c_cmd_timeout #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;
  logic             running;

  // Load on start, count down while running, park at zero until cleared.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count   <= '0;
      running <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      count   <= LOAD_VAL;
      running <= 1'b1;
    end else if (running && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = running && (count == '0);

endmodule

// File: rtl/axi_lite_i2c_cmd_bridge.sv
// AXI4-Lite slave that turns each AXI write/read into one I2C register
// write/read command, one transaction in flight at a time.
module axi_lite_i2c_cmd_bridge #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [7:0]        i2c_addr,
  output logic [7:0]        i2c_din,
  output logic [6:0]        i2c_slv_addr,
  output logic              i2c_op_type,
  output logic              i2c_trigger,
  input  logic [7:0]        i2c_dout,
  input  logic              i2c_busy,
  input  logic              i2c_done,
  input  logic              i2c_ack_err
);

  import axi_i2c_pkg::*;

  state_t state, state_next;

  // active keeps every ready low while reset is held, then opens IDLE.
  logic active;

  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_buf;
  logic [7:0]        w_buf;
  logic              strb_buf;

  logic [7:0]        addr_q, din_q;
  logic [6:0]        slv_q;
  logic              op_q, rsv_q, strb_q;
  logic [1:0]        resp_q, resp_next;
  logic [DATA_W-1:0] rdata_q, rdata_next;

  logic ar_fire, aw_fire, w_fire;
  logic aw_have, w_have, accepting, collect_done;
  logic trigger, expired, timer_clear;
  logic [ADDR_W-1:0] wr_addr;

  logic unused_bits;
  assign unused_bits = ^{s_wdata[DATA_W-1:8], s_wstrb[DATA_W/8-1:1]};

  function automatic logic addr_reserved(input logic [ADDR_W-1:0] a);
    return (a >> (SLV_MSB + 1)) != '0;
  endfunction

  // Read wins arbitration in IDLE: AW/W readies drop while ARVALID is high.
  assign s_arready = active && (state == IDLE);
  assign s_awready = active && (((state == IDLE) && !s_arvalid) ||
                                ((state == WR_COLLECT) && !aw_held));
  assign s_wready  = active && (((state == IDLE) && !s_arvalid) ||
                                ((state == WR_COLLECT) && !w_held));

  assign ar_fire = s_arvalid && s_arready;
  assign aw_fire = s_awvalid && s_awready;
  assign w_fire  = s_wvalid  && s_wready;

  assign aw_have      = aw_held || aw_fire;
  assign w_have       = w_held  || w_fire;
  assign accepting    = (state == IDLE) || (state == WR_COLLECT);
  assign collect_done = accepting && aw_have && w_have;
  assign wr_addr      = aw_fire ? s_awaddr : aw_buf;

  assign s_bvalid     = (state == WR_RESP);
  assign s_rvalid     = (state == RD_RESP);
  assign s_bresp      = resp_q;
  assign s_rresp      = resp_q;
  assign s_rdata      = rdata_q;
  assign i2c_addr     = addr_q;
  assign i2c_din      = din_q;
  assign i2c_slv_addr = slv_q;
  assign i2c_op_type  = op_q;
  assign i2c_trigger  = trigger;

  assign timer_clear = ((state == WR_RESP) && s_bready) ||
                       ((state == RD_RESP) && s_rready);

  i2c_cmd_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .start  (trigger),
    .clear  (timer_clear),
    .expired(expired)
  );

  // State register plus the post-reset enable for the readies.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      active <= 1'b0;
    end else begin
      state  <= state_next;
      active <= 1'b1;
    end
  end

  // Next state, trigger strobe and response/read-data updates.
  always_comb begin
    state_next = state;
    resp_next  = resp_q;
    rdata_next = rdata_q;
    trigger    = 1'b0;
    case (state)
      IDLE: begin
        if (ar_fire || collect_done) state_next = ISSUE;
        else if (aw_fire || w_fire)  state_next = WR_COLLECT;
      end
      WR_COLLECT: begin
        if (collect_done) state_next = ISSUE;
      end
      ISSUE: begin
        if (rsv_q) begin
          resp_next  = RESP_DECERR;
          rdata_next = '0;
          state_next = op_q ? RD_RESP : WR_RESP;
        end else if (!op_q && !strb_q) begin
          resp_next  = RESP_SLVERR;
          state_next = WR_RESP;
        end else if (!i2c_busy) begin
          trigger    = 1'b1;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i2c_done) begin
          resp_next = i2c_ack_err ? RESP_SLVERR : RESP_OKAY;
          if (op_q) rdata_next = {{(DATA_W-8){1'b0}}, i2c_dout};
          state_next = op_q ? RD_RESP : WR_RESP;
        end else if (expired) begin
          resp_next  = RESP_SLVERR;
          rdata_next = '0;
          state_next = op_q ? RD_RESP : WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_bready) state_next = IDLE;
      end
      RD_RESP: begin
        if (s_rready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Half-collected writes, command registers and the response registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_buf   <= '0;
      w_buf    <= '0;
      strb_buf <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      slv_q    <= '0;
      op_q     <= 1'b0;
      rsv_q    <= 1'b0;
      strb_q   <= 1'b0;
      resp_q   <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      resp_q  <= resp_next;
      rdata_q <= rdata_next;
      if (ar_fire) begin
        addr_q <= s_araddr[REG_MSB:0];
        slv_q  <= s_araddr[SLV_MSB:SLV_LSB];
        op_q   <= 1'b1;
        rsv_q  <= addr_reserved(s_araddr);
      end else if (collect_done) begin
        addr_q  <= wr_addr[REG_MSB:0];
        slv_q   <= wr_addr[SLV_MSB:SLV_LSB];
        op_q    <= 1'b0;
        rsv_q   <= addr_reserved(wr_addr);
        din_q   <= w_fire ? s_wdata[7:0] : w_buf;
        strb_q  <= w_fire ? s_wstrb[0] : strb_buf;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_fire) begin
          aw_held <= 1'b1;
          aw_buf  <= s_awaddr;
        end
        if (w_fire) begin
          w_held   <= 1'b1;
          w_buf    <= s_wdata[7:0];
          strb_buf <= s_wstrb[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_i2c_cmd_bridge.sv
// Directed self-checking bench for axi_lite_i2c_cmd_bridge with a small
// behavioural I2C master (done three cycles after the trigger unless hung).
module tb_axi_lite_i2c_cmd_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b0;
  logic [15:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic [7:0]  i2c_addr, i2c_din, i2c_dout;
  logic [6:0]  i2c_slv_addr;
  logic        i2c_op_type, i2c_trigger;
  logic        i2c_busy = 1'b0;
  logic        i2c_done;
  logic        i2c_ack_err;

  int errors = 0;
  int checks = 0;

  int          trig_count = 0;
  int          mdl_cnt;
  logic [6:0]  cap_slv;
  logic [7:0]  cap_addr, cap_din;
  logic        cap_op;
  logic        master_hang = 1'b0;
  logic        master_nack = 1'b0;
  logic [7:0]  master_dout = '0;

  assign i2c_ack_err = master_nack;
  assign i2c_dout    = master_dout;

  always #5 clk = ~clk;

  axi_lite_i2c_cmd_bridge #(
    .ADDR_W(16), .DATA_W(32), .TIMEOUT_CYC(50)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .i2c_addr(i2c_addr), .i2c_din(i2c_din), .i2c_slv_addr(i2c_slv_addr),
    .i2c_op_type(i2c_op_type), .i2c_trigger(i2c_trigger), .i2c_dout(i2c_dout),
    .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_ack_err(i2c_ack_err)
  );

  // Behavioural I2C master: counts and captures triggers, answers with done.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mdl_cnt  <= 0;
      i2c_done <= 1'b0;
    end else begin
      i2c_done <= 1'b0;
      if (i2c_trigger) begin
        trig_count <= trig_count + 1;
        cap_slv    <= i2c_slv_addr;
        cap_addr   <= i2c_addr;
        cap_din    <= i2c_din;
        cap_op     <= i2c_op_type;
        mdl_cnt    <= master_hang ? 0 : 3;
      end else if (mdl_cnt != 0) begin
        mdl_cnt <= mdl_cnt - 1;
        if (mdl_cnt == 1) i2c_done <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sendAw(input logic [15:0] addr);
    int n;
    s_awaddr  = addr;
    s_awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_awready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!s_awready) checkOutput("aw_handshake_bound", 0, 1);
    @(posedge clk); #1;
    s_awvalid = 1'b0;
  endtask

  task automatic sendW(input logic [31:0] data, input logic [3:0] strb);
    int n;
    s_wdata  = data;
    s_wstrb  = strb;
    s_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_wready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!s_wready) checkOutput("w_handshake_bound", 0, 1);
    @(posedge clk); #1;
    s_wvalid = 1'b0;
  endtask

  task automatic sendAr(input logic [15:0] addr);
    int n;
    s_araddr  = addr;
    s_arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_arready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!s_arready) checkOutput("ar_handshake_bound", 0, 1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
  endtask

  // lat: cycles from done to valid; cyc: cycles from call to valid (inclusive).
  task automatic waitB(output logic [1:0] resp, output int lat, output int cyc);
    int n, done_at;
    bit seen;
    done_at  = -100;
    seen     = 1'b0;
    s_bready = 1'b1;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (s_bvalid) begin
        seen = 1'b1;
        break;
      end
      if (i2c_done) done_at = n;
    end
    if (!seen) checkOutput("b_wait_bound", 0, 1);
    cyc  = n + 1;
    lat  = n - done_at;
    resp = s_bresp;
    @(posedge clk); #1;
    s_bready = 1'b0;
  endtask

  task automatic waitR(output logic [1:0] resp, output logic [31:0] data,
                       output int lat, output int cyc);
    int n, done_at;
    bit seen;
    done_at  = -100;
    seen     = 1'b0;
    s_rready = 1'b1;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (s_rvalid) begin
        seen = 1'b1;
        break;
      end
      if (i2c_done) done_at = n;
    end
    if (!seen) checkOutput("r_wait_bound", 0, 1);
    cyc  = n + 1;
    lat  = n - done_at;
    resp = s_rresp;
    data = s_rdata;
    @(posedge clk); #1;
    s_rready = 1'b0;
  endtask

  // Hard stop so a wedged handshake can never hang the run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat, cyc, t0;
    bit          flag;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_readies", {s_arready, s_awready, s_wready}, 3'b000);
    checkOutput("rst_valids", {s_bvalid, s_rvalid, i2c_trigger}, 3'b000);
    checkOutput("rst_cmd", {i2c_op_type, i2c_slv_addr, i2c_addr, i2c_din}, 24'h0);
    checkOutput("rst_resp", {s_bresp, s_rresp}, 4'h0);
    checkOutput("rst_rdata", s_rdata, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("idle_readies", {s_arready, s_awready, s_wready}, 3'b111);
    @(posedge clk); #1;

    // Basic write 0x5D01 <= 0x3A
    $display("[TB] basic write");
    t0 = trig_count;
    fork
      sendAw(16'h5D01);
      sendW(32'h0000_003A, 4'h1);
    join
    @(negedge clk);
    checkOutput("wr_trig_latency", i2c_trigger, 1'b1);
    waitB(resp, lat, cyc);
    checkOutput("wr_bresp", resp, 2'b00);
    checkOutput("wr_b_latency", lat, 1);
    checkOutput("wr_trig_count", trig_count - t0, 1);
    checkOutput("wr_cmd", {cap_op, cap_slv, cap_addr, cap_din}, {1'b0, 7'h5D, 8'h01, 8'h3A});

    // Basic read 0x5D02 -> 0xA5
    $display("[TB] basic read");
    t0 = trig_count;
    master_dout = 8'hA5;
    sendAr(16'h5D02);
    waitR(resp, rdata, lat, cyc);
    checkOutput("rd_rresp", resp, 2'b00);
    checkOutput("rd_rdata", rdata, 32'h0000_00A5);
    checkOutput("rd_r_latency", lat, 1);
    checkOutput("rd_trig_count", trig_count - t0, 1);
    checkOutput("rd_cmd", {cap_op, cap_slv, cap_addr}, {1'b1, 7'h5D, 8'h02});
    @(negedge clk);
    checkOutput("rd_rvalid_drop", s_rvalid, 1'b0);
    @(posedge clk); #1;

    // W three cycles ahead of AW
    $display("[TB] W before AW");
    t0 = trig_count;
    sendW(32'h0000_0077, 4'h1);
    repeat (3) @(negedge clk);
    checkOutput("collect_readies", {s_awready, s_wready, s_arready}, 3'b100);
    checkOutput("collect_no_trig", trig_count - t0, 0);
    @(posedge clk); #1;
    sendAw(16'h2210);
    waitB(resp, lat, cyc);
    checkOutput("wfirst_bresp", resp, 2'b00);
    checkOutput("wfirst_trig_count", trig_count - t0, 1);
    checkOutput("wfirst_cmd", {cap_op, cap_slv, cap_addr, cap_din}, {1'b0, 7'h22, 8'h10, 8'h77});

    // AR together with AW/W: the read goes first
    $display("[TB] read/write collision");
    t0 = trig_count;
    master_dout = 8'h3C;
    s_araddr = 16'h5D03; s_arvalid = 1'b1;
    s_awaddr = 16'h5D04; s_awvalid = 1'b1;
    s_wdata  = 32'h0000_00C7; s_wstrb = 4'h1; s_wvalid = 1'b1;
    @(negedge clk);
    checkOutput("arb_readies", {s_arready, s_awready, s_wready}, 3'b100);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    @(negedge clk);
    checkOutput("arb_busy_readies", {s_awready, s_wready}, 2'b00);
    @(posedge clk); #1;
    waitR(resp, rdata, lat, cyc);
    checkOutput("arb_read_cmd", {cap_op, cap_slv, cap_addr}, {1'b1, 7'h5D, 8'h03});
    checkOutput("arb_rdata", rdata, 32'h0000_003C);
    fork
      sendAw(16'h5D04);
      sendW(32'h0000_00C7, 4'h1);
    join
    waitB(resp, lat, cyc);
    checkOutput("arb_write_cmd", {cap_op, cap_slv, cap_addr, cap_din}, {1'b0, 7'h5D, 8'h04, 8'hC7});
    checkOutput("arb_trig_count", trig_count - t0, 2);
    checkOutput("arb_bresp", resp, 2'b00);

    // NACK write, issued only once the master stops being busy
    $display("[TB] nack write with busy master");
    master_nack = 1'b1;
    i2c_busy    = 1'b1;
    fork
      sendAw(16'h4C20);
      sendW(32'hFFFF_FF99, 4'hF);
    join
    flag = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (i2c_trigger) flag = 1'b0;
    end
    checkOutput("busy_holds_trig", flag, 1'b1);
    @(posedge clk); #1;
    i2c_busy = 1'b0;
    @(negedge clk);
    checkOutput("busy_release_trig", i2c_trigger, 1'b1);
    waitB(resp, lat, cyc);
    checkOutput("nack_bresp", resp, 2'b10);
    checkOutput("nack_din", cap_din, 8'h99);
    master_nack = 1'b0;

    // Reserved address bit -> DECERR, no trigger
    $display("[TB] decode errors");
    t0 = trig_count;
    fork
      sendAw(16'h8001);
      sendW(32'h0000_0011, 4'h1);
    join
    waitB(resp, lat, cyc);
    checkOutput("decerr_bresp", resp, 2'b11);
    checkOutput("decerr_cycles", cyc, 2);
    checkOutput("decerr_no_trig", trig_count - t0, 0);

    // Byte-0 strobe clear -> SLVERR, no trigger
    fork
      sendAw(16'h5D05);
      sendW(32'h0000_0022, 4'h0);
    join
    waitB(resp, lat, cyc);
    checkOutput("strb_bresp", resp, 2'b10);
    checkOutput("strb_no_trig", trig_count - t0, 0);

    // Back-pressure on B for ten cycles with a competing AW
    $display("[TB] bready held low");
    t0 = trig_count;
    fork
      sendAw(16'h3344);
      sendW(32'h0000_0066, 4'h1);
    join
    s_bready = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_bvalid) begin
        flag = 1'b1;
        break;
      end
    end
    checkOutput("hold_bvalid_seen", flag, 1'b1);
    resp = s_bresp;
    s_awaddr  = 16'h0102;
    s_awvalid = 1'b1;
    flag = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!s_bvalid || (s_bresp !== resp) || s_awready) flag = 1'b0;
    end
    checkOutput("hold_stable", flag, 1'b1);
    checkOutput("hold_bresp", resp, 2'b00);
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    s_bready  = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    @(negedge clk);
    checkOutput("hold_release", {s_bvalid, s_awready}, 2'b01);
    checkOutput("hold_trig_count", trig_count - t0, 1);
    @(posedge clk); #1;

    // Master never answers: timeout after 50 wait cycles
    $display("[TB] timeout read");
    master_hang = 1'b1;
    master_dout = 8'hFF;
    sendAr(16'h5D06);
    waitR(resp, rdata, lat, cyc);
    checkOutput("to_rresp", resp, 2'b10);
    checkOutput("to_rdata", rdata, 32'h0);
    checkOutput("to_cycles", cyc, 52);
    master_hang = 1'b0;

    master_dout = 8'h96;
    sendAr(16'h0A0B);
    waitR(resp, rdata, lat, cyc);
    checkOutput("rd2_rdata", rdata, 32'h0000_0096);
    checkOutput("rd2_rresp", resp, 2'b00);

    // Reset asserted while waiting for done
    $display("[TB] reset mid-transaction");
    master_hang = 1'b1;
    sendAr(16'h1122);
    repeat (5) @(negedge clk);
    checkOutput("pre_rst_state", {s_arready, i2c_op_type, i2c_slv_addr}, {1'b0, 1'b1, 7'h11});
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("midrst_ctrl",
                {s_arready, s_awready, s_wready, s_bvalid, s_rvalid, i2c_trigger, i2c_op_type},
                7'h0);
    checkOutput("midrst_cmd", {i2c_slv_addr, i2c_addr, i2c_din}, 23'h0);
    checkOutput("midrst_rdata", s_rdata, 32'h0);
    checkOutput("midrst_resp", {s_bresp, s_rresp}, 4'h0);
    @(negedge clk);
    resetn      = 1'b1;
    master_hang = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("post_rst_readies", {s_arready, s_awready, s_wready}, 3'b111);
    @(posedge clk); #1;
    fork
      sendAw(16'h5D01);
      sendW(32'h0000_0042, 4'h1);
    join
    waitB(resp, lat, cyc);
    checkOutput("post_rst_bresp", resp, 2'b00);
    checkOutput("post_rst_din", cap_din, 8'h42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_i2c_cmd_bridge.md
Name: axi_lite_i2c_cmd_bridge

Overview:
AXI4-Lite slave front end of the AXI-to-I2C bridge, directly upstream of the I2C master.
Converts each AXI write into one I2C register write and each AXI read into one I2C register read.
Issues each command with a single-cycle trigger, waits for the master's done, then returns the AXI response.
Exactly one transaction is in flight at a time. There is no queueing.

Parameters:
ADDR_W, 16, AXI address width; must be ≥ 16.
DATA_W, 32, AXI data width; only bits [7:0] carry payload.
TIMEOUT_CYC, 100000, number of clk cycles allowed in WAIT_DONE before abort.

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous and active-low
s_awaddr  in  ADDR_W  write address: [14:8] = I2C slave address, [7:0] = register address, [15] and above reserved
s_awvalid  in  1  AXI write-address valid
s_awready  out  1  AXI write-address ready
s_wdata  in  DATA_W  write data; [7:0] is the byte written
s_wstrb  in  DATA_W/8  write strobes
s_wvalid  in  1  AXI write-data valid
s_wready  out  1  AXI write-data ready
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  ADDR_W  read address; same field map as s_awaddr
s_arvalid  in  1  AXI read-address valid
s_arready  out  1  AXI read-address ready
s_rdata  out  DATA_W  read data; byte zero-extended
s_rresp  out  2  read response
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
i2c_addr  out  8  register address to the master
i2c_din  out  8  write byte to the master
i2c_slv_addr  out  7  7-bit I2C slave address
i2c_op_type  out  1  0 = write, 1 = read
i2c_trigger  out  1  one-cycle command strobe
i2c_dout  in  8  read byte from the master
i2c_busy  in  1  master busy
i2c_done  in  1  one-cycle completion pulse from the master
i2c_ack_err  in  1  NACK seen; valid while i2c_done is high

Behaviour:
- Reset (resetn low, asynchronous): state = IDLE.
  - All ready/valid outputs, i2c_trigger and the timeout counter are 0.
  - s_bresp, s_rresp, s_rdata, i2c_addr, i2c_din and i2c_slv_addr are 0; i2c_op_type is 0.
  - Reset mid-transaction abandons it; the I2C master is reset by the same resetn.
- FSM states: IDLE, WR_COLLECT, ISSUE, WAIT_DONE, WR_RESP, RD_RESP.
- IDLE:
  - s_arready, s_awready and s_wready are all 1.
  - Read wins if s_arvalid is high in the same cycle as s_awvalid or s_wvalid. In that case only the AR handshake completes; AW and W stay pending.
  - Read accept: latch araddr, set op_type = 1, go to ISSUE.
  - Write: AW and W may complete in either order, or together. If only one completes, go to WR_COLLECT; its ready drops and the other ready stays 1.
  - When both AW and W are held, latch addr, wdata[7:0] and wstrb[0], set op_type = 0, go to ISSUE.
- Decode checks, applied in ISSUE:
  - Any reserved address bit set → no trigger; go to the response state with DECERR (2'b11).
  - Write with wstrb[0] = 0 → no trigger; response SLVERR (2'b10).
- ISSUE:
  - Wait for i2c_busy = 0.
  - Then drive i2c_trigger = 1 for exactly one cycle and go to WAIT_DONE.
  - Command outputs are stable from entry to ISSUE until the next ISSUE.
- WAIT_DONE:
  - The counter increments every cycle.
  - On i2c_done = 1, capture ack_err and, for reads, i2c_dout.
  - Response is SLVERR if ack_err is set, else OKAY (2'b00).
  - If the counter reaches TIMEOUT_CYC - 1 without done: SLVERR, rdata = 0.
  - If done and timeout occur in the same cycle, done wins.
- Latency: trigger asserts 1 cycle after the address/data accept when the master is idle. bvalid/rvalid assert 1 cycle after i2c_done.
- WR_RESP / RD_RESP:
  - Hold bvalid or rvalid, with resp and data stable, until the matching ready is seen.
  - Then go to IDLE and clear the counter.
  - A ready already high on the first valid cycle completes in that cycle.
- No new address or data is accepted outside IDLE/WR_COLLECT. While a transaction is outstanding, all readies are 0.

Decomposition:
- Package axi_i2c_pkg holds:
  - state enum;
  - RESP_OKAY, RESP_SLVERR and RESP_DECERR constants;
  - field-position constants SLV_LSB = 8, SLV_MSB = 14 and REG_MSB = 7.
- One natural sub-module: i2c_cmd_timeout. It is a loadable down-counter with start, clear and expired signals.

Test Plan:
- Write to awaddr 0x5D01 with wdata 0x3A and wstrb 0x1; master returns done with ack_err = 0.
  → one trigger pulse with slv_addr 0x5D, addr 0x01, din 0x3A, op_type 0; then bresp OKAY.
- Read from araddr 0x5D02; master returns dout 0xA5 → op_type 1, then rdata 0x000000A5 with rresp OKAY.
- W arrives 3 cycles before AW → exactly one trigger, issued only after the AW handshake. The same test with ar and aw asserted in the same cycle → the read is serviced first, then the write.
- Master returns ack_err = 1 on done → bresp SLVERR. Master never returns done, with TIMEOUT_CYC = 50 → rresp SLVERR and rdata 0 after 50 cycles.
- Write to awaddr 0x8001 → DECERR with no trigger. Write with wstrb 0x0 → SLVERR with no trigger.
- Hold bready low for 10 cycles → bvalid and bresp stay stable and no new AW is accepted. Assert resetn low inside WAIT_DONE → all outputs return to 0 immediately.
